// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Data-memory access stage of the MIPS54 pipeline, sitting directly upstream of
// the load extender. Accepts one load/store request at a time from the core,
// checks alignment, drives a word-addressed data memory with byte enables, waits
// for acknowledge (bounded by TIMEOUT cycles) and, for loads, returns the
// addressed byte/halfword right-justified together with the extend-select code
// the load extender consumes.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_req                   request strobe, sampled only while idle
//   i_we                    1 = store, 0 = load
//   i_size                  00 word, 01 half, 10 byte, 11 treated as word
//   i_sign                  loads only: 1 = sign-extend, 0 = zero-extend
//   i_addr                  byte address
//   i_wdata                 store data, right-justified
//   o_busy                  high from the cycle after accept until done/err
//   o_done                  one-cycle pulse on successful completion
//   o_addr_err              one-cycle pulse on a misaligned request
//   o_bus_err               one-cycle pulse on memory timeout
//   o_ld_word               load data, right-justified, valid with o_done
//   o_ld_sel                extend select for the load extender
//   o_mem_req, o_mem_we     memory request / write enable
//   o_mem_be                byte enables, bit i covers bits 8i+7:8i
//   o_mem_addr              word address {addr[31:2],2'b00}
//   o_mem_wdata             store data replicated into byte lanes
//   i_mem_rdata, i_mem_ack  memory read data / completion
//
// State | meaning
// IDLE   | waiting for a request; alignment checked here
// ACCESS | memory request outstanding, counting wait cycles
// RESP   | one cycle; emits done or bus_err and updates load result
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_addr_err,
    output logic        o_bus_err,
    output logic [31:0] o_ld_word,
    output logic [2:0]  o_ld_sel,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Last wait count before giving up; the access lasts TIMEOUT cycles in total.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_we;
    logic        r_sign;
    logic        r_err;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;

    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_capture;
    logic [2:0]  w_sel;
    logic        w_leave;

    // Request decode from the live inputs. Size 11 falls into the word branch.
    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b1111;
        w_wdata   = i_wdata;
        case (i_size)
            2'b01: begin
                w_aligned = ~i_addr[0];
                w_be      = 4'b0011 << i_addr[1:0];
                w_wdata   = {2{i_wdata[15:0]}};
            end
            2'b10: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << i_addr[1:0];
                w_wdata   = {4{i_wdata[7:0]}};
            end
            default: begin
                w_aligned = (i_addr[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = i_wdata;
            end
        endcase
    end

    // Load data alignment and extend-select from the latched request.
    always_comb begin
        w_shifted = i_mem_rdata >> {r_off, 3'b000};
        w_capture = w_shifted;
        w_sel     = 3'b000;
        case (r_size)
            2'b01: begin
                w_capture = {16'h0000, w_shifted[15:0]};
                w_sel     = r_sign ? 3'b011 : 3'b001;
            end
            2'b10: begin
                w_capture = {24'h000000, w_shifted[7:0]};
                w_sel     = r_sign ? 3'b100 : 3'b010;
            end
            default: begin
                w_capture = w_shifted;
                w_sel     = 3'b000;
            end
        endcase
    end

    // Leave ACCESS on acknowledge, or when the wait budget is exhausted.
    assign w_leave = i_mem_ack || (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_sign      <= 1'b0;
            r_err       <= 1'b0;
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            r_cnt       <= 8'd0;
            r_rdata     <= 32'h0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_addr_err  <= 1'b0;
            o_bus_err   <= 1'b0;
            o_ld_word   <= 32'h0;
            o_ld_sel    <= 3'b000;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= 4'b0000;
            o_mem_addr  <= 32'h0;
            o_mem_wdata <= 32'h0;
        end else begin
            o_done     <= 1'b0;
            o_addr_err <= 1'b0;
            o_bus_err  <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (i_req) begin
                        if (w_aligned) begin
                            r_we        <= i_we;
                            r_size      <= i_size;
                            r_sign      <= i_sign;
                            r_off       <= i_addr[1:0];
                            r_cnt       <= 8'd0;
                            r_err       <= 1'b0;
                            o_busy      <= 1'b1;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_we;
                            o_mem_be    <= w_be;
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_wdata <= w_wdata;
                            r_state     <= ACCESS;
                        end else begin
                            o_addr_err <= 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    if (w_leave) begin
                        // Memory bus returns to quiet as soon as the access ends.
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_be    <= 4'b0000;
                        o_mem_addr  <= 32'h0;
                        o_mem_wdata <= 32'h0;
                        r_err       <= ~i_mem_ack;
                        if (i_mem_ack) begin
                            r_rdata <= w_capture;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                RESP: begin
                    o_busy    <= 1'b0;
                    r_cnt     <= 8'd0;
                    o_done    <= ~r_err;
                    o_bus_err <= r_err;
                    // Only a successful load touches ld_word; stores and
                    // timeouts leave it alone but reset the select to word.
                    if (!r_err && !r_we) begin
                        o_ld_word <= r_rdata;
                        o_ld_sel  <= w_sel;
                    end else begin
                        o_ld_sel <= 3'b000;
                    end
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TO = 4;

    localparam int T_NONE = 0;
    localparam int T_LW   = 1;
    localparam int T_LBS  = 2;
    localparam int T_LBU  = 3;
    localparam int T_SH   = 4;
    localparam int T_MIS  = 5;
    localparam int T_TO   = 6;
    localparam int T_RST  = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_addr_err;
    logic        o_bus_err;
    logic [31:0] o_ld_word;
    logic [2:0]  o_ld_sel;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_size      (size),
        .i_sign      (sign),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_addr_err  (o_addr_err),
        .o_bus_err   (o_bus_err),
        .o_ld_word   (o_ld_word),
        .o_ld_sel    (o_ld_sel),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_be    (o_mem_be),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack)
    );

    // Expected outputs for the current cycle, set by the stimulus schedule.
    logic        e_busy = 0, e_done = 0, e_aerr = 0, e_berr = 0;
    logic        e_mreq = 0, e_mwe = 0;
    logic [3:0]  e_mbe = 0;
    logic [31:0] e_maddr = 0, e_mwdata = 0;
    logic [31:0] m_ldw = 0;
    logic [2:0]  m_lds = 0;

    int errors = 0;
    int checks = 0;
    int tag = T_NONE;
    int mreq_run = 0;
    int busy_run = 0;

    function automatic logic f_aligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b01:   return (off[0] == 1'b0);
            2'b10:   return 1'b1;
            default: return (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b01:   return 4'b0011 << off;
            2'b10:   return 4'b0001 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_wd(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b01:   return {2{wd[15:0]}};
            2'b10:   return {4{wd[7:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] f_cap(input logic [1:0] sz, input logic [1:0] off,
                                          input logic [31:0] rd);
        logic [31:0] s;
        s = rd >> (8 * int'(off));
        case (sz)
            2'b01:   return s & 32'h0000FFFF;
            2'b10:   return s & 32'h000000FF;
            default: return s;
        endcase
    endfunction

    function automatic logic [2:0] f_sel(input logic [1:0] sz, input logic sg);
        case (sz)
            2'b01:   return sg ? 3'd3 : 3'd1;
            2'b10:   return sg ? 3'd4 : 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: model vs DUT every cycle, plus literal pins.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy",      32'(o_busy),      32'(e_busy));
            chk("done",      32'(o_done),      32'(e_done));
            chk("addr_err",  32'(o_addr_err),  32'(e_aerr));
            chk("bus_err",   32'(o_bus_err),   32'(e_berr));
            chk("mem_req",   32'(o_mem_req),   32'(e_mreq));
            chk("mem_we",    32'(o_mem_we),    32'(e_mwe));
            chk("mem_be",    32'(o_mem_be),    32'(e_mbe));
            chk("mem_addr",  o_mem_addr,       e_maddr);
            chk("mem_wdata", o_mem_wdata,      e_mwdata);
            chk("ld_word",   o_ld_word,        m_ldw);
            chk("ld_sel",    32'(o_ld_sel),    32'(m_lds));

            if (!rst_n) begin
                mreq_run = 0;
                busy_run = 0;
                if (tag == T_RST) begin
                    chk("rst mem_req", 32'(o_mem_req), 32'd0);
                    chk("rst done",    32'(o_done),    32'd0);
                end
            end else begin
                if (o_mem_req) mreq_run++;
                if (o_busy) busy_run++;
                if (o_mem_req) begin
                    case (tag)
                        T_LW: begin
                            chk("lw mem_be",   32'(o_mem_be), 32'h0000000F);
                            chk("lw mem_addr", o_mem_addr,    32'h00000100);
                            chk("lw mem_we",   32'(o_mem_we), 32'd0);
                        end
                        T_LBS, T_LBU: begin
                            chk("lb mem_be",   32'(o_mem_be), 32'h00000008);
                            chk("lb mem_addr", o_mem_addr,    32'h00000100);
                        end
                        T_SH: begin
                            chk("sh mem_we",    32'(o_mem_we), 32'd1);
                            chk("sh mem_be",    32'(o_mem_be), 32'h0000000C);
                            chk("sh mem_addr",  o_mem_addr,    32'h00000204);
                            chk("sh mem_wdata", o_mem_wdata,   32'hABCDABCD);
                        end
                        default: ;
                    endcase
                end
                if (tag == T_MIS) begin
                    chk("mis mem_req", 32'(o_mem_req), 32'd0);
                    chk("mis busy",    32'(o_busy),    32'd0);
                end
                if (o_done || o_bus_err) begin
                    case (tag)
                        T_LW: begin
                            chk("lw ld_word",    o_ld_word,    32'hDEADBEEF);
                            chk("lw ld_sel",     32'(o_ld_sel), 32'd0);
                            chk("lw req cycles", 32'(mreq_run), 32'd1);
                            chk("lw busy cycles", 32'(busy_run), 32'd2);
                        end
                        T_LBS: begin
                            chk("lbs ld_word", o_ld_word,     32'h00000080);
                            chk("lbs ld_sel",  32'(o_ld_sel), 32'd4);
                        end
                        T_LBU: begin
                            chk("lbu ld_word", o_ld_word,     32'h00000080);
                            chk("lbu ld_sel",  32'(o_ld_sel), 32'd2);
                        end
                        T_SH: begin
                            chk("sh done",   32'(o_done),   32'd1);
                            chk("sh ld_sel", 32'(o_ld_sel), 32'd0);
                        end
                        T_TO: begin
                            chk("to bus_err",     32'(o_bus_err), 32'd1);
                            chk("to req cycles",  32'(mreq_run),  32'd4);
                            chk("to busy cycles", 32'(busy_run),  32'd5);
                        end
                        default: ;
                    endcase
                    mreq_run = 0;
                    busy_run = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_busy = 0; e_done = 0; e_aerr = 0; e_berr = 0;
        e_mreq = 0; e_mwe = 0; e_mbe = 0; e_maddr = 0; e_mwdata = 0;
    endtask

    // Junk on the request inputs once a request has been taken.
    task automatic scramble();
        req   = 1'b0;
        we    = 1'($urandom);
        size  = 2'($urandom);
        sign  = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
    endtask

    task automatic gap();
        req       = 1'b0;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        step();
        set_idle();
    endtask

    // One request; t_wait = number of wait cycles before ack (>= TO means none).
    task automatic txn(input logic t_we, input logic [1:0] t_sz, input logic t_sign,
                       input logic [31:0] t_addr, input logic [31:0] t_wdata,
                       input logic [31:0] t_rdata, input int t_wait);
        int   c;
        logic ack_now;
        logic timed_out;
        req = 1'b1; we = t_we; size = t_sz; sign = t_sign; addr = t_addr; wdata = t_wdata;
        step();
        scramble();
        set_idle();
        if (!f_aligned(t_sz, t_addr[1:0])) begin
            e_aerr = 1;
            return;
        end
        e_busy   = 1;
        e_mreq   = 1;
        e_mwe    = t_we;
        e_mbe    = f_be(t_sz, t_addr[1:0]);
        e_maddr  = {t_addr[31:2], 2'b00};
        e_mwdata = f_wd(t_sz, t_wdata);
        c = 0;
        timed_out = 0;
        forever begin
            ack_now   = (c == t_wait);
            mem_ack   = ack_now;
            mem_rdata = ack_now ? t_rdata : $urandom;
            req       = 1'($urandom);
            addr      = {$urandom_range(0, 255), 2'b00};
            step();
            if (ack_now) break;
            if (c == TO - 1) begin
                timed_out = 1;
                break;
            end
            c++;
        end
        set_idle();
        e_busy    = 1;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        req       = 1'($urandom);
        step();
        set_idle();
        if (timed_out) begin
            e_berr = 1;
            m_lds  = 0;
        end else begin
            e_done = 1;
            if (!t_we) begin
                m_ldw = f_cap(t_sz, t_addr[1:0], t_rdata);
                m_lds = f_sel(t_sz, t_sign);
            end else begin
                m_lds = 0;
            end
        end
        req     = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        rst_n = 0; req = 0; we = 0; size = 0; sign = 0; addr = 0; wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        set_idle();
        m_ldw = 0;
        m_lds = 0;
        repeat (3) step();
        rst_n = 1;
        step();

        tag = T_LW;
        txn(1'b0, 2'b00, 1'b0, 32'h00000100, 32'h12345678, 32'hDEADBEEF, 0);
        gap();
        tag = T_LBS;
        txn(1'b0, 2'b10, 1'b1, 32'h00000103, 32'h0, 32'h80112233, 1);
        gap();
        tag = T_LBU;
        txn(1'b0, 2'b10, 1'b0, 32'h00000103, 32'h0, 32'h80112233, 2);
        gap();
        tag = T_SH;
        txn(1'b1, 2'b01, 1'b0, 32'h00000206, 32'h0000ABCD, 32'h55555555, 0);
        gap();
        tag = T_MIS;
        txn(1'b0, 2'b00, 1'b0, 32'h00000102, 32'h0, 32'h0, 0);
        gap();
        txn(1'b0, 2'b01, 1'b0, 32'h00000101, 32'h0, 32'h0, 0);
        gap();
        gap();
        tag = T_TO;
        txn(1'b0, 2'b00, 1'b0, 32'h00000040, 32'h0, 32'h0, TO + 2);
        gap();
        tag = T_NONE;
        txn(1'b0, 2'b01, 1'b1, 32'h00000042, 32'h0, 32'h8001C0DE, TO - 1);
        gap();

        tag = T_RST;
        req = 1; we = 0; size = 2'b00; sign = 0; addr = 32'h00000300; wdata = 32'h0;
        step();
        req = 0;
        mem_ack = 0;
        set_idle();
        e_busy = 1; e_mreq = 1; e_mbe = 4'hF; e_maddr = 32'h00000300; e_mwdata = 32'h0;
        step();
        step();
        rst_n = 0;
        set_idle();
        m_ldw = 0;
        m_lds = 0;
        step();
        step();
        rst_n = 1;
        step();
        tag = T_NONE;
        txn(1'b0, 2'b00, 1'b0, 32'h00000300, 32'h0, 32'hCAFEF00D, 3);
        gap();

        for (int i = 0; i < 250; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            txn(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, $urandom,
                $urandom_range(0, TO + 1));
            repeat ($urandom_range(0, 2)) gap();
        end

        gap();
        gap();
        #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
